// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state type, default parameters and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } uart_rx_state_e;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    // Parity bit a transmitter appends after the data: even parity (odd = 0) makes the
    // total count of ones even. Narrower words are passed zero-extended.
    function automatic logic uart_parity(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer with selectable reset value
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the reset value matches an idle line so no false edge appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: mid-bit sampling FSM with valid/ready byte output
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_BIT = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_e state_q, state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
    logic                 par_bad_q, par_bad_d;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic baud_tick;
    logic stop_done;
    logic stop_bad;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign baud_tick = (baud_cnt_q == '0);

    // Frame-tracking FSM: find the start edge, then sample every bit at its centre.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_reg_d = shift_reg_q;
        par_bad_d   = par_bad_q;
        stop_done   = 1'b0;
        stop_bad    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    baud_cnt_d = HALF_BIT;
                    par_bad_d  = 1'b0;
                end
            end
            START: begin
                if (!baud_tick) begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end else if (!rx_s) begin
                    state_d    = DATA;
                    bit_cnt_d  = '0;
                    baud_cnt_d = FULL_BIT;
                end else begin
                    // Line went back high before mid-bit: a glitch, not a start bit.
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!baud_tick) begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end else begin
                    // LSB arrives first, so after DATA_BITS right-shifts it sits at bit 0.
                    shift_reg_d = {rx_s, shift_reg_q[DATA_BITS-1:1]};
                    baud_cnt_d  = FULL_BIT;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (!baud_tick) begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end else begin
                    par_bad_d  = uart_parity(9'(shift_reg_q), PARITY_ODD != 0) ^ rx_s;
                    baud_cnt_d = FULL_BIT;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (!baud_tick) begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end else begin
                    stop_done = 1'b1;
                    stop_bad  = !rx_s;
                    state_d   = rx_s ? IDLE : WAIT_HI;
                end
            end
            WAIT_HI: begin
                // A held-low line is a break; never mistake it for a new start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output holding register: deliver a finished frame or flag an overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (stop_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_reg_q;
                parity_err_d = par_bad_q;
                frame_err_d  = stop_bad;
                rx_valid_d   = 1'b1;
            end else begin
                // Consumer still holds the previous frame: keep it, drop the new one.
                overrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_reg_q  <= '0;
            par_bad_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_reg_q  <= shift_reg_d;
            par_bad_q    <= par_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and random frames against a bit-counting reference model
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    frame_t got_q[$];
    int     valid_cycles = 0;
    int     ovr_count = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_EN    (1),
        .PARITY_ODD   (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Observe transfers and pulses between edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cycles++;
            if (overrun) ovr_count++;
            if (rx_valid && rx_ready) got_q.push_back('{d: rx_data, pe: parity_err, fe: frame_err});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Number of ones in a byte, counted one bit at a time.
    function automatic int ones_of(input logic [7:0] d);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(d[i]);
        return c;
    endfunction

    // Even-parity bit a correct transmitter would send.
    function automatic logic good_par(input logic [7:0] d);
        return (ones_of(d) % 2) == 1;
    endfunction

    // Reference: with even parity, the data ones plus the parity bit must total an even count.
    function automatic logic model_perr(input logic [7:0] d, input logic pbit);
        return ((ones_of(d) + int'(pbit)) % 2) != 0;
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input bit trail);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(stop);
        if (trail) send_bit(1'b1);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pbit, input logic stop);
        frame_t f;
        check({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            f = got_q.pop_front();
            check({tag, "_data"}, f.d, d);
            check({tag, "_perr"}, f.pe, model_perr(d, pbit));
            check({tag, "_ferr"}, f.fe, !stop);
        end
        got_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       pb;
        int         vc;

        // Reset state
        #1 rst_n = 1'b0;
        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(CPB);

        // 1: clean 0xA5
        valid_cycles = 0;
        send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b1);
        expect_frame("t1", 8'hA5, good_par(8'hA5), 1'b1);
        check("t1_valid_1clk", valid_cycles, 1);
        check("t1_valid_low", rx_valid, 0);

        // 2: short glitch is rejected
        valid_cycles = 0;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(CPB - 5);
        check("t2_busy_idle", busy, 0);
        check("t2_no_valid", valid_cycles, 0);
        check("t2_no_frame", got_q.size(), 0);

        // 3: wrong parity bit flagged
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        expect_frame("t3", 8'h3C, 1'b1, 1'b1);

        // 4: framing error, break, then a clean frame
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        tick(40);
        expect_frame("t4", 8'h00, 1'b0, 1'b0);
        check("t4_break_busy", busy, 1);
        check("t4_no_second", got_q.size(), 0);
        rx = 1'b1;
        tick(4);
        check("t4_release_idle", busy, 0);
        tick(CPB);
        send_frame(8'h55, good_par(8'h55), 1'b1, 1'b1);
        expect_frame("t4b", 8'h55, good_par(8'h55), 1'b1);

        // 5: back-pressure and overrun
        rx_ready = 1'b0;
        ovr_count = 0;
        send_frame(8'h11, good_par(8'h11), 1'b1, 1'b1);
        check("t5_pending", rx_valid, 1);
        check("t5_first_data", rx_data, 8'h11);
        send_frame(8'h22, good_par(8'h22), 1'b1, 1'b1);
        check("t5_held_data", rx_data, 8'h11);
        check("t5_still_valid", rx_valid, 1);
        check("t5_overrun_once", ovr_count, 1);
        check("t5_no_transfer", got_q.size(), 0);
        rx_ready = 1'b1;
        tick(2);
        check("t5_cleared", rx_valid, 0);
        expect_frame("t5", 8'h11, good_par(8'h11), 1'b1);

        // 6: reset in the middle of 0xF0's data bits
        send_bit(1'b0);
        d = 8'hF0;
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rst_n = 1'b0;
        rx = 1'b1;
        tick(2);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(CPB);
        check("t6_no_partial", got_q.size(), 0);
        send_frame(8'h0F, good_par(8'h0F), 1'b1, 1'b1);
        expect_frame("t6", 8'h0F, good_par(8'h0F), 1'b1);

        // Random frames with random parity correctness and idle gaps
        for (int i = 0; i < 10; i++) begin
            d  = 8'($urandom);
            pb = ($urandom_range(0, 1) == 1) ? good_par(d) : !good_par(d);
            tick($urandom_range(0, CPB));
            vc = valid_cycles;
            send_frame(d, pb, 1'b1, 1'b1);
            expect_frame($sformatf("rnd%0d", i), d, pb, 1'b1);
            check($sformatf("rnd%0d_vc", i), valid_cycles - vc, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
